fact_seq_ctrl: RTL and testbench

- Control FSM for the factorial register-file datapath (the `General` block).
- Accepts a start request with operand n and issues per-cycle register-file addresses, ALU operation, write-data select and write enable.
- Consumes the datapath's `is_zero` flag and reports busy/done/err to the top level.
- It is the initiating end of the datapath control interface; the datapath responds.

---
 rtl/fact_pkg.sv | 26 ++
 rtl/fact_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fact_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared state encoding, ALU opcodes and register-file map for the factorial sequencer.
package fact_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_N,
      S_LOAD_ONE,
      S_LOAD_ACC,
      S_TEST,
      S_MUL,
      S_DEC,
      S_DONE
   } state_t;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SUB    = 3'b001;
   localparam logic [2:0] OP_MUL    = 3'b010;
   localparam logic [2:0] OP_PASS_A = 3'b011;

   localparam logic [1:0] R_N   = 2'd0;
   localparam logic [1:0] R_ACC = 2'd1;
   localparam logic [1:0] R_ONE = 2'd2;

   localparam int FACT_MAX_N = 12;

endpackage

// File: rtl/fact_seq_ctrl.sv
// Control FSM driving the factorial register-file datapath (R0 = n, R1 = acc, R2 = 1).
// Optional out-of-range rejection is enabled by defining FACT_RANGE_CHECK_EN.
module fact_seq_ctrl
   import fact_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_W    = 5,
   parameter int MAX_N  = FACT_MAX_N
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_W-1:0]    n_in,
   input  logic              is_zero,
   output logic [1:0]        read_add1,
   output logic [1:0]        read_add2,
   output logic [1:0]        write_add,
   output logic [2:0]        operation,
   output logic              wd_selec,
   output logic              read_imm,
   output logic [DATA_W-1:0] imm,
   output logic              write_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

`ifdef FACT_RANGE_CHECK_EN
   localparam bit RangeChk = 1'b1;
`else
   localparam bit RangeChk = 1'b0;
`endif

   state_t              r_state;
   state_t              w_state_nx;
   logic [N_W-1:0]      r_nq;
   logic [N_W-1:0]      w_nq_nx;
   logic                w_over;

   logic [1:0]          w_ra1, w_ra2, w_wa;
   logic [2:0]          w_op;
   logic                w_wdsel, w_we, w_busy, w_done, w_err;
   logic [DATA_W-1:0]   w_imm;

   logic [1:0]          r_ra1, r_ra2, r_wa;
   logic [2:0]          r_op;
   logic                r_wdsel, r_we, r_busy, r_done, r_err;
   logic [DATA_W-1:0]   r_imm;

   assign w_over = RangeChk && (int'(n_in) > MAX_N);

   always_comb begin
      w_state_nx = r_state;
      w_nq_nx    = r_nq;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nq_nx    = n_in;
               w_state_nx = w_over ? S_DONE : S_LOAD_N;
            end
         end
         S_LOAD_N:   w_state_nx = S_LOAD_ONE;
         S_LOAD_ONE: w_state_nx = S_LOAD_ACC;
         S_LOAD_ACC: w_state_nx = S_TEST;
         S_TEST:     w_state_nx = is_zero ? S_DONE : S_MUL;
         S_MUL:      w_state_nx = S_DEC;
         S_DEC:      w_state_nx = S_TEST;
         S_DONE:     w_state_nx = S_IDLE;
         default:    w_state_nx = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copy matches the state it lands in.
   always_comb begin
      w_ra1   = R_N;
      w_ra2   = R_N;
      w_wa    = R_N;
      w_op    = OP_PASS_A;
      w_wdsel = 1'b0;
      w_we    = 1'b0;
      w_imm   = '0;
      w_busy  = (w_state_nx != S_IDLE);
      w_done  = 1'b0;
      w_err   = 1'b0;
      case (w_state_nx)
         S_LOAD_N: begin
            w_wa    = R_N;
            w_wdsel = 1'b1;
            w_we    = 1'b1;
            w_imm   = DATA_W'(w_nq_nx);
         end
         S_LOAD_ONE: begin
            w_wa    = R_ONE;
            w_wdsel = 1'b1;
            w_we    = 1'b1;
            w_imm   = DATA_W'(1);
         end
         S_LOAD_ACC: begin
            w_wa    = R_ACC;
            w_wdsel = 1'b1;
            w_we    = 1'b1;
            w_imm   = DATA_W'(1);
         end
         S_TEST: begin
            w_ra1 = R_N;
         end
         S_MUL: begin
            w_ra1 = R_ACC;
            w_ra2 = R_N;
            w_op  = OP_MUL;
            w_wa  = R_ACC;
            w_we  = 1'b1;
         end
         S_DEC: begin
            w_ra1 = R_N;
            w_ra2 = R_ONE;
            w_op  = OP_SUB;
            w_wa  = R_N;
            w_we  = 1'b1;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_err  = RangeChk && (int'(w_nq_nx) > MAX_N);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_nq    <= '0;
         r_ra1   <= R_N;
         r_ra2   <= R_N;
         r_wa    <= R_N;
         r_op    <= OP_PASS_A;
         r_wdsel <= 1'b0;
         r_we    <= 1'b0;
         r_imm   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_nq    <= w_nq_nx;
         r_ra1   <= w_ra1;
         r_ra2   <= w_ra2;
         r_wa    <= w_wa;
         r_op    <= w_op;
         r_wdsel <= w_wdsel;
         r_we    <= w_we;
         r_imm   <= w_imm;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_err   <= w_err;
      end
   end

   assign read_add1 = r_ra1;
   assign read_add2 = r_ra2;
   assign write_add = r_wa;
   assign operation = r_op;
   assign wd_selec  = r_wdsel;
   assign read_imm  = r_wdsel;
   assign imm       = r_imm;
   assign write_en  = r_we;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Bench for fact_seq_ctrl: behavioural register-file/ALU datapath plus a result scoreboard.
// Expectations for n > MAX_N follow FACT_RANGE_CHECK_EN when it is defined.
module tb_fact_seq_ctrl;
   import fact_pkg::*;

   localparam int DATA_W = 32;
   localparam int N_W    = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [N_W-1:0]    n_in = '0;
   logic              is_zero;
   logic [1:0]        read_add1, read_add2, write_add;
   logic [2:0]        operation;
   logic              wd_selec, read_imm, write_en, busy, done, err;
   logic [DATA_W-1:0] imm;

   always #5 clk = ~clk;

   fact_seq_ctrl #(.DATA_W(DATA_W), .N_W(N_W), .MAX_N(12)) dut (
      .clk(clk), .reset(reset), .start(start), .n_in(n_in), .is_zero(is_zero),
      .read_add1(read_add1), .read_add2(read_add2), .write_add(write_add),
      .operation(operation), .wd_selec(wd_selec), .read_imm(read_imm), .imm(imm),
      .write_en(write_en), .busy(busy), .done(done), .err(err)
   );

   // Datapath model: 4-entry register file with a combinational ALU.
   logic [DATA_W-1:0] rf [4];
   logic [DATA_W-1:0] alu_a, alu_b, alu_y;

   always_comb begin
      alu_a = rf[read_add1];
      alu_b = rf[read_add2];
      case (operation)
         OP_ADD:  alu_y = alu_a + alu_b;
         OP_SUB:  alu_y = alu_a - alu_b;
         OP_MUL:  alu_y = alu_a * alu_b;
         default: alu_y = alu_a;
      endcase
   end
   assign is_zero = (alu_y == '0);

   always @(posedge clk) begin
      if (write_en) rf[write_add] <= wd_selec ? imm : alu_y;
   end

   int wr_cnt = 0, mul_cnt = 0, dec_cnt = 0, done_cnt = 0, busy_cnt = 0;
   always @(negedge clk) begin
      if (write_en) wr_cnt <= wr_cnt + 1;
      if (write_en && operation == OP_MUL) mul_cnt <= mul_cnt + 1;
      if (write_en && operation == OP_SUB) dec_cnt <= dec_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   typedef struct {
      int          n;
      logic [31:0] r1;
      int          lat;
      logic        err;
      int          iters;
      int          wr;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_start(input int n, input logic [31:0] r1_exp, input bit track);
      exp_t e;
      sample();
      start = 1'b1;
      n_in  = N_W'(n);
      if (track) begin
         e.n = n;
`ifdef FACT_RANGE_CHECK_EN
         if (n > 12) begin
            e.r1 = 'x; e.lat = 1; e.err = 1'b1; e.iters = 0; e.wr = 0;
         end else begin
            e.r1 = r1_exp; e.lat = 5 + 3 * n; e.err = 1'b0; e.iters = n; e.wr = 3 + 2 * n;
         end
`else
         e.r1 = r1_exp; e.lat = 5 + 3 * n; e.err = 1'b0; e.iters = n; e.wr = 3 + 2 * n;
`endif
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int glitch);
      exp_t e;
      int cyc = 0;
      bit seen = 0;
      int w0 = wr_cnt, m0 = mul_cnt, d0 = dec_cnt, b0 = busy_cnt, dn0;
      e = sb.pop_front();
      while (cyc < 400 && !seen) begin
         @(posedge clk);
         cyc++;
         sample();
         if (cyc == 1) start = 1'b0;
         if (cyc == glitch) begin start = 1'b1; n_in = N_W'(3); end
         if (cyc == glitch + 1) start = 1'b0;
         if (done) seen = 1;
      end
      chk($sformatf("done_seen_n%0d", e.n), 64'(seen), 64'd1);
      chk($sformatf("latency_n%0d", e.n), 64'(cyc), 64'(e.lat));
      chk($sformatf("err_n%0d", e.n), 64'(err), 64'(e.err));
      chk($sformatf("busy_with_done_n%0d", e.n), 64'(busy), 64'd1);
      if (!e.err) chk($sformatf("R1_n%0d", e.n), 64'(rf[R_ACC]), 64'(e.r1));
      chk($sformatf("mul_writes_n%0d", e.n), 64'(mul_cnt - m0), 64'(e.iters));
      chk($sformatf("dec_writes_n%0d", e.n), 64'(dec_cnt - d0), 64'(e.iters));
      chk($sformatf("all_writes_n%0d", e.n), 64'(wr_cnt - w0), 64'(e.wr));
      chk($sformatf("busy_cycles_n%0d", e.n), 64'(busy_cnt - b0), 64'(e.lat));
      dn0 = done_cnt;
      sample();
      chk($sformatf("done_single_n%0d", e.n), 64'(done), 64'd0);
      chk($sformatf("idle_busy_n%0d", e.n), 64'(busy), 64'd0);
      chk($sformatf("idle_err_n%0d", e.n), 64'(err), 64'd0);
      repeat (8) sample();
      chk($sformatf("no_extra_done_n%0d", e.n), 64'(done_cnt - dn0), 64'd0);
   endtask

   initial begin
      int m0, dn0, w0, cyc;
      bit hit;

      // Reset state.
      reset = 1'b0;
      repeat (3) sample();
      chk("rst_write_en", 64'(write_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_operation", 64'(operation), 64'(OP_PASS_A));
      chk("rst_addrs", 64'({read_add1, read_add2, write_add}), 64'd0);
      chk("rst_imm", 64'(imm), 64'd0);
      chk("rst_wd_selec", 64'(wd_selec), 64'd0);
      chk("rst_read_imm", 64'(read_imm), 64'd0);
      reset = 1'b1;
      repeat (2) sample();
      chk("idle_no_busy", 64'(busy), 64'd0);

      drive_start(0, 32'd1, 1'b1);
      wait_done(-10);

      drive_start(5, 32'd120, 1'b1);
      wait_done(-10);

      drive_start(12, 32'd479001600, 1'b1);
      wait_done(-10);

      // Start pulsed with a new operand while busy must be ignored.
      drive_start(5, 32'd120, 1'b1);
      wait_done(4);

      // Reset during the third MUL.
      m0 = mul_cnt;
      dn0 = done_cnt;
      drive_start(5, 32'd0, 1'b0);
      hit = 0;
      cyc = 0;
      while (cyc < 100 && !hit) begin
         sample();
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (mul_cnt - m0 == 3 && write_en && operation == OP_MUL) hit = 1;
      end
      chk("reached_third_mul", 64'(hit), 64'd1);
      reset = 1'b0;
      sample();
      chk("midrst_write_en", 64'(write_en), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      reset = 1'b1;
      w0 = wr_cnt;
      repeat (10) sample();
      chk("midrst_no_done", 64'(done_cnt - dn0), 64'd0);
      chk("midrst_no_writes", 64'(wr_cnt - w0), 64'd0);
      drive_start(3, 32'd6, 1'b1);
      wait_done(-10);

      drive_start(13, 32'd1932053504, 1'b1);
      wait_done(-10);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
